// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per cycle into a word store,
// then a registered round-key read port. Define KEYEXP_EQINV_EN to add equivalent-inverse keys.
module aes_key_expander #(
    parameter int unsigned KEY_WORDS = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [32*KEY_WORDS-1:0] key_i,
`ifdef KEYEXP_EQINV_EN
    input  logic                   rk_inv_i,
`endif
    input  logic [3:0]             rk_index_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   key_valid_o,
    output logic [127:0]           rk_out_o
);
    localparam int unsigned NR = KEY_WORDS + 6;
    localparam int unsigned NW = 4 * (NR + 1);

    typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as a^254 (the product of a^2..a^128), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] y;
        logic [7:0] v;
        y = a;
        v = 8'h01;
        for (int k = 1; k < 8; k++) begin
            y = gf_mul(y, y);
            v = gf_mul(v, y);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

`ifdef KEYEXP_EQINV_EN
    function automatic logic [31:0] inv_mix(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction
`endif

    state_e        state_q;
    logic [5:0]    i_q;
    logic [2:0]    j_q;
    logic [7:0]    rcon_q;
    logic          busy_q, done_q, key_valid_q;
    logic [127:0]  rk_q;
    logic [31:0]   w_q [NW];

    logic          load, step;
    logic [5:0]    i_prev, i_back, rk_base;
    logic [31:0]   prev_w, sub_in, sub_out, temp, new_w;
    logic [127:0]  rk_plain, rk_d;

    always_comb begin
        load    = start_i && (state_q != StExpand);
        step    = (state_q == StExpand);
        i_prev  = i_q - 6'd1;
        i_back  = i_q - 6'(KEY_WORDS);
        prev_w  = w_q[i_prev];
        sub_in  = (j_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
        sub_out = sub_word(sub_in);
        if (j_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if (KEY_WORDS == 8 && j_q == 3'd4) begin
            temp = sub_out;
        end else begin
            temp = prev_w;
        end
        new_w = w_q[i_back] ^ temp;

        rk_base  = {rk_index_i, 2'b00};
        rk_plain = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
        rk_d     = (rk_index_i <= 4'(NR)) ? rk_plain : 128'h0;
`ifdef KEYEXP_EQINV_EN
        if (rk_inv_i && rk_index_i != 4'd0 && rk_index_i < 4'(NR)) begin
            rk_d = {inv_mix(rk_plain[127:96]), inv_mix(rk_plain[95:64]),
                    inv_mix(rk_plain[63:32]), inv_mix(rk_plain[31:0])};
        end
`endif
    end

    // Word store is not reset; its contents only matter once key_valid is set.
    always_ff @(posedge clk_i) begin
        if (load) begin
            for (int k = 0; k < KEY_WORDS; k++) begin
                w_q[k] <= key_i[32*(KEY_WORDS-1-k) +: 32];
            end
        end else if (step) begin
            w_q[i_q] <= new_w;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            i_q         <= 6'd0;
            j_q         <= 3'd0;
            rcon_q      <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_valid_q <= 1'b0;
            rk_q        <= 128'h0;
        end else begin
            rk_q   <= rk_d;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StReady: begin
                    if (start_i) begin
                        i_q         <= 6'(KEY_WORDS);
                        j_q         <= 3'd0;
                        rcon_q      <= 8'h01;
                        key_valid_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= StExpand;
                    end
                end
                StExpand: begin
                    if (j_q == 3'd0) rcon_q <= xtime(rcon_q);
                    i_q <= i_q + 6'd1;
                    j_q <= (j_q == 3'(KEY_WORDS - 1)) ? 3'd0 : j_q + 3'd1;
                    if (i_q == 6'(NW - 1)) begin
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        key_valid_q <= 1'b1;
                        state_q     <= StReady;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign key_valid_o = key_valid_q;
    assign rk_out_o    = rk_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: AES-128/192/256 instances side by side, FIPS-197 vectors,
// restart/ignore/abort behaviour and the out-of-range read port; EQINV checks when enabled.
module tb_aes_key_expander;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_s   [3];
    logic          start_s [3];
    logic [255:0]  key_s   [3];
    logic [3:0]    idx_s   [3];
    logic          busy_s  [3];
    logic          done_s  [3];
    logic          kv_s    [3];
    logic [127:0]  rk_s    [3];
`ifdef KEYEXP_EQINV_EN
    logic          inv_s   [3];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned NkG = 4 + 2 * g;
        aes_key_expander #(.KEY_WORDS(NkG)) u_dut (
            .clk_i       (clk),
            .rst_i       (rst_s[g]),
            .start_i     (start_s[g]),
            .key_i       (key_s[g][32*NkG-1:0]),
`ifdef KEYEXP_EQINV_EN
            .rk_inv_i    (inv_s[g]),
`endif
            .rk_index_i  (idx_s[g]),
            .busy_o      (busy_s[g]),
            .done_o      (done_s[g]),
            .key_valid_o (kv_s[g]),
            .rk_out_o    (rk_s[g])
        );
    end

    localparam logic [255:0] K128  = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] K192  = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256  =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z128_1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z128_10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {
        string        tag;
        logic [127:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Expected value is queued as the index is driven and compared once the read edge passes.
    task automatic read_rk(input int g, input logic [3:0] idx, input logic [127:0] exp,
                           input string tag);
        sb_item_t it;
        idx_s[g] = idx;
        sb_q.push_back('{tag: tag, exp: exp});
        tick();
        it = sb_q.pop_front();
        check_eq(it.tag, rk_s[g], it.exp);
    endtask

    // poke_at > 0 raises start with a different key at that EXPAND cycle; it must be ignored.
    task automatic run_expand(input int g, input logic [255:0] key, input int exp_cyc,
                              input int poke_at, input string tag);
        int n;
        key_s[g]   = key;
        start_s[g] = 1'b1;
        tick();
        start_s[g] = 1'b0;
        check_eq({tag, " busy"}, 128'(busy_s[g]), 128'd1);
        check_eq({tag, " kv_drop"}, 128'(kv_s[g]), 128'd0);
        n = 0;
        do begin
            tick();
            n++;
            start_s[g] = (n == poke_at);
            key_s[g]   = (n == poke_at) ? ~key : key;
        end while (!done_s[g] && n < 200);
        start_s[g] = 1'b0;
        check_eq({tag, " done_cycles"}, 128'(n), 128'(exp_cyc));
        check_eq({tag, " kv"}, 128'(kv_s[g]), 128'd1);
        check_eq({tag, " busy_low"}, 128'(busy_s[g]), 128'd0);
        tick();
        check_eq({tag, " done_pulse"}, 128'(done_s[g]), 128'd0);
    endtask

`ifdef KEYEXP_EQINV_EN
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) r ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return r;
    endfunction

    function automatic logic [127:0] ref_inv_mix(input logic [127:0] rk);
        logic [127:0] o;
        logic [7:0]   c [4];
        logic [7:0]   m [4];
        m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 4; b++) c[b] = rk[127 - 32*w - 8*b -: 8];
            for (int r = 0; r < 4; r++) begin
                o[127 - 32*w - 8*r -: 8] = ref_mul(c[0], m[(4 - r) % 4]) ^
                                           ref_mul(c[1], m[(5 - r) % 4]) ^
                                           ref_mul(c[2], m[(6 - r) % 4]) ^
                                           ref_mul(c[3], m[(7 - r) % 4]);
            end
        end
        return o;
    endfunction
`endif

    initial begin
        for (int g = 0; g < 3; g++) begin
            rst_s[g]   = 1'b1;
            start_s[g] = 1'b0;
            key_s[g]   = '0;
            idx_s[g]   = 4'd0;
`ifdef KEYEXP_EQINV_EN
            inv_s[g]   = 1'b0;
`endif
        end
        tick();
        tick();
        for (int g = 0; g < 3; g++) begin
            check_eq($sformatf("rst_busy%0d", g), 128'(busy_s[g]), 128'd0);
            check_eq($sformatf("rst_done%0d", g), 128'(done_s[g]), 128'd0);
            check_eq($sformatf("rst_kv%0d", g), 128'(kv_s[g]), 128'd0);
            check_eq($sformatf("rst_rk%0d", g), rk_s[g], 128'd0);
            rst_s[g] = 1'b0;
        end
        tick();

        // AES-128 with an ignored start at EXPAND cycle 10
        run_expand(0, K128, 40, 10, "a128");
        read_rk(0, 4'd0, K128[127:0], "a128_rk0");
        read_rk(0, 4'd1, R128_1, "a128_rk1");
        read_rk(0, 4'd10, R128_10, "a128_rk10");
        read_rk(0, 4'd11, 128'd0, "a128_rk11_oor");

`ifdef KEYEXP_EQINV_EN
        inv_s[0] = 1'b1;
        read_rk(0, 4'd0, K128[127:0], "eqinv_rk0");
        read_rk(0, 4'd10, R128_10, "eqinv_rk10");
        read_rk(0, 4'd1, ref_inv_mix(R128_1), "eqinv_rk1");
        inv_s[0] = 1'b0;
`endif

        // AES-192 and AES-256
        run_expand(1, K192, 46, 0, "a192");
        read_rk(1, 4'd0, K192[191:64], "a192_rk0");
        read_rk(1, 4'd12, 128'he98ba06f448c773c8ecc720401002202, "a192_rk12");
        read_rk(1, 4'd13, 128'd0, "a192_rk13_oor");
        run_expand(2, K256, 52, 0, "a256");
        read_rk(2, 4'd1, K256[127:0], "a256_rk1");
        read_rk(2, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, "a256_rk14");
        read_rk(2, 4'd15, 128'd0, "a256_rk15_oor");

        // Restart from READY with the all-zero key
        run_expand(0, 256'd0, 40, 0, "restart");
        read_rk(0, 4'd1, Z128_1, "restart_rk1");
        read_rk(0, 4'd10, Z128_10, "restart_rk10");

        // Abort mid-expansion, then re-expand from scratch
        key_s[0]   = K128;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        idx_s[0]   = 4'd0;
        repeat (19) tick();
        #2 rst_s[0] = 1'b1;
        #1;
        check_eq("abort_busy", 128'(busy_s[0]), 128'd0);
        check_eq("abort_done", 128'(done_s[0]), 128'd0);
        check_eq("abort_kv", 128'(kv_s[0]), 128'd0);
        check_eq("abort_rk", rk_s[0], 128'd0);
        tick();
        rst_s[0] = 1'b0;
        tick();
        run_expand(0, K128, 40, 0, "after_abort");
        read_rk(0, 4'd1, R128_1, "after_abort_rk1");
        read_rk(0, 4'd10, R128_10, "after_abort_rk10");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
